// File: rtl/coin_pkg.sv
// Shared coin encoding used by the coin acceptor and the vending-machine FSM.
package coin_pkg;

   typedef logic [1:0] coin_t;

   localparam coin_t COIN_NONE = 2'b00;
   localparam coin_t COIN_5    = 2'b01;
   localparam coin_t COIN_10   = 2'b10;

   // A simultaneous press never gets pushed, so the 10 Rs priority here is moot.
   function automatic coin_t ev_code(input logic ev5, input logic ev10);
      coin_t code;
      code = COIN_NONE;
      if (ev10)
         code = COIN_10;
      else if (ev5)
         code = COIN_5;
      return code;
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// One button path: 2-flop synchronizer, stability counter and rising-edge event.
module coin_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic ev
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          lvl_q;
   logic          lvl_d1_q;
   logic [CW-1:0] cnt_q;

   // A 1-bit level that differs from the debounced level for TC+1 edges in a
   // row has not changed in that window, so matching the level resets the count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q   <= 2'b00;
         lvl_q    <= 1'b0;
         lvl_d1_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[0], btn};
         lvl_d1_q <= lvl_q;
         if (sync_q[1] == lvl_q) begin
            cnt_q <= '0;
         end else if (cnt_q == TC) begin
            lvl_q <= sync_q[1];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign ev = lvl_q & ~lvl_d1_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounced buttons -> event buffer -> one coin code per tick.
// COIN_ACCEPTOR_FIFO_EN selects a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          btn_5,
   input  logic                          btn_10,
   input  logic                          tick,
   output logic [1:0]                    coin,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow,
   output logic                          dual_err
);

   localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

   logic  ev5;
   logic  ev10;
   logic  push_req;
   logic  push_ok;
   logic  pop;
   logic  full;
   logic  empty;
   coin_t push_code;
   coin_t head;

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_5 (
      .clk (clk),
      .rst (rst),
      .btn (btn_5),
      .ev  (ev5)
   );

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_10 (
      .clk (clk),
      .rst (rst),
      .btn (btn_10),
      .ev  (ev10)
   );

   assign push_req  = ev5 ^ ev10;
   assign push_code = ev_code(ev5, ev10);
   assign empty     = (count == '0);
   assign pop       = tick & ~empty;
   // A pop in the same cycle frees the slot, so a full buffer still accepts.
   assign push_ok   = push_req & (~full | pop);

`ifdef COIN_ACCEPTOR_FIFO_EN
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   coin_t          mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q;
   logic [AW-1:0]  rd_ptr_q;

   assign full = (count == CNTW'(FIFO_DEPTH));
   assign head = mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_q] <= push_code;
   end
`else
   coin_t hold_q;

   assign full = count[0];
   assign head = hold_q;

   always_ff @(posedge clk) begin
      if (!rst)
         hold_q <= COIN_NONE;
      else if (push_ok)
         hold_q <= push_code;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         coin     <= COIN_NONE;
         count    <= '0;
         overflow <= 1'b0;
         dual_err <= 1'b0;
      end else begin
         dual_err <= ev5 & ev10;
         if (push_req & ~push_ok)
            overflow <= 1'b1;
         if (push_ok & ~pop)
            count <= count + CNTW'(1);
         else if (pop & ~push_ok)
            count <= count - CNTW'(1);
         if (tick)
            coin <= empty ? COIN_NONE : head;
      end
   end

endmodule
